// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared aluop codes, FSM states and stall vectors for the stall controller.
package pipe_ctrl_pkg;
  typedef logic [7:0] alu_op_t;
  localparam alu_op_t EXE_DIV_OP   = 8'b00011010;
  localparam alu_op_t EXE_DIVU_OP  = 8'b00011011;
  localparam alu_op_t EXE_MADD_OP  = 8'b10100110;
  localparam alu_op_t EXE_MADDU_OP = 8'b10101000;
  localparam alu_op_t EXE_MSUB_OP  = 8'b10101010;
  localparam alu_op_t EXE_MSUBU_OP = 8'b10101011;
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE, MADD2} state_t;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  function automatic logic is_div(alu_op_t op);
    return op == EXE_DIV_OP || op == EXE_DIVU_OP;
  endfunction
  function automatic logic is_madd(alu_op_t op);
    return op == EXE_MADD_OP || op == EXE_MADDU_OP || op == EXE_MSUB_OP || op == EXE_MSUBU_OP;
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: decode/EX requests into the stall controller and its stall/datapath controls.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;
  logic       stallreq_id_i;
  logic       ex_valid_i;
  alu_op_t    ex_aluop_i;
  logic       ex_div_zero_i;
  logic       flush_i;
  logic [5:0] stall_o;
  logic       div_start_o;
  logic       div_step_o;
  logic [5:0] div_cnt_o;
  logic       div_done_o;
  logic       div_dz_o;
  logic       madd_phase_o;
  logic       busy_o;
  modport master (
    output stallreq_id_i, ex_valid_i, ex_aluop_i, ex_div_zero_i, flush_i,
    input  stall_o, div_start_o, div_step_o, div_cnt_o, div_done_o, div_dz_o, madd_phase_o, busy_o
  );
  modport slave (
    input  stallreq_id_i, ex_valid_i, ex_aluop_i, ex_div_zero_i, flush_i,
    output stall_o, div_start_o, div_step_o, div_cnt_o, div_done_o, div_dz_o, madd_phase_o, busy_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges decode stall requests with multi-cycle DIV/MADD sequencing into a
// per-stage stall vector and drives the shared EX arithmetic step/phase controls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam logic [5:0] LAST = 6'(DIV_CYCLES - 1);
  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d, stall;
  logic       dz_q, dz_d, ex_stall, start, step, phase;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;
    ex_stall = 1'b0;
    start    = 1'b0;
    step     = 1'b0;
    phase    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ex_valid_i && is_div(bus.ex_aluop_i)) begin
          ex_stall = 1'b1;
          state_d  = bus.ex_div_zero_i ? DIV_DONE : DIV_RUN;
          dz_d     = bus.ex_div_zero_i;
          start    = !bus.ex_div_zero_i;
          cnt_d    = '0;
        end else if (bus.ex_valid_i && is_madd(bus.ex_aluop_i)) begin
          ex_stall = 1'b1;
          state_d  = MADD2;
        end
      end
      DIV_RUN: begin
        ex_stall = 1'b1;
        step     = 1'b1;
        state_d  = cnt_q == LAST ? DIV_DONE : DIV_RUN;
        cnt_d    = cnt_q == LAST ? 6'd0 : cnt_q + 6'd1;
      end
      DIV_DONE: begin
        state_d = IDLE;
        dz_d    = 1'b0;
      end
      MADD2: begin
        phase   = 1'b1;
        state_d = IDLE;
      end
    endcase
    // Flush annuls any in-flight op, including one being accepted this cycle.
    if (bus.flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      dz_d     = 1'b0;
      ex_stall = 1'b0;
      start    = 1'b0;
      step     = 1'b0;
    end
    stall = bus.flush_i ? STALL_NONE : ex_stall ? STALL_EX : bus.stallreq_id_i ? STALL_ID : STALL_NONE;
  end
  assign bus.stall_o      = stall;
  assign bus.div_start_o  = start;
  assign bus.div_step_o   = step;
  assign bus.div_cnt_o    = cnt_q;
  assign bus.div_done_o   = state_q == DIV_DONE;
  assign bus.div_dz_o     = state_q == DIV_DONE && dz_q;
  assign bus.madd_phase_o = phase;
  assign bus.busy_o       = state_q != IDLE;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed stimulus with a per-instruction reference model
// feeding an expected-output queue that a negedge monitor drains and compares.
module tb_pipe_ctrl;
  localparam int N = 32;
  localparam logic [7:0] DIV = 8'b00011010, DIVU = 8'b00011011;
  localparam logic [7:0] MADD = 8'b10100110, MADDU = 8'b10101000;
  localparam logic [7:0] MSUB = 8'b10101010, MSUBU = 8'b10101011;
  localparam logic [7:0] ADD = 8'h20, ORR = 8'h25;
  typedef struct packed {
    logic [5:0] stall;
    logic       start;
    logic       step;
    logic [5:0] cnt;
    logic       done;
    logic       dz;
    logic       phase;
    logic       busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  pipe_ctrl_if bus ();
  pipe_ctrl #(.DIV_CYCLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    exp_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{bus.stall_o, bus.div_start_o, bus.div_step_o, bus.div_cnt_o, bus.div_done_o,
            bus.div_dz_o, bus.madd_phase_o, bus.busy_o};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t got stall=%b start=%b step=%b cnt=%0d done=%b dz=%b phase=%b busy=%b exp stall=%b start=%b step=%b cnt=%0d done=%b dz=%b phase=%b busy=%b",
                 $time, g.stall, g.start, g.step, g.cnt, g.done, g.dz, g.phase, g.busy,
                 e.stall, e.start, e.step, e.cnt, e.done, e.dz, e.phase, e.busy);
      end
    end
  end
  task automatic drive(input logic r, input logic v, input logic [7:0] op, input logic z,
                       input logic id, input logic fl, input exp_t e);
    @(posedge clk);
    #1;
    rst = r;
    bus.ex_valid_i = v;
    bus.ex_aluop_i = op;
    bus.ex_div_zero_i = z;
    bus.stallreq_id_i = id;
    bus.flush_i = fl;
    q.push_back(e);
  endtask
  task automatic idle_cycle(input logic r);
    drive(r, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
  endtask
  // One instruction occupying EX from acceptance to release; later cycles get junk EX inputs.
  task automatic issue(input logic v, input logic [7:0] op, input logic z, input logic id_all, input int stop_at);
    exp_t e;
    logic isd, ism, r;
    int len;
    isd = v && (op == DIV || op == DIVU);
    ism = v && (op == MADD || op == MADDU || op == MSUB || op == MSUBU);
    len = isd ? (z ? 2 : N + 2) : ism ? 2 : 1;
    for (int k = 0; k < len && k < stop_at; k++) begin
      r = id_all | 1'($urandom_range(0, 1));
      e = '0;
      e.busy = k > 0;
      if (k == 0) begin
        e.stall = (isd || ism) ? 6'b001111 : r ? 6'b000111 : 6'b000000;
        e.start = isd && !z;
      end else if (k == len - 1) begin
        e.stall = r ? 6'b000111 : 6'b000000;
        e.done  = isd;
        e.dz    = isd && z;
        e.phase = ism;
      end else begin
        e.stall = 6'b001111;
        e.step  = 1'b1;
        e.cnt   = 6'(k - 1);
      end
      if (k == 0) drive(1'b1, v, op, z, r, 1'b0, e);
      else drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), r, 1'b0, e);
    end
  endtask
  initial begin
    exp_t e;
    logic [7:0] ops [8] = '{DIV, DIVU, MADD, MADDU, MSUB, MSUBU, ADD, ORR};
    bus.ex_valid_i = 1'b0;
    bus.ex_aluop_i = 8'h00;
    bus.ex_div_zero_i = 1'b0;
    bus.stallreq_id_i = 1'b0;
    bus.flush_i = 1'b0;
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    issue(1'b1, DIVU, 1'b0, 1'b0, 1000);
    issue(1'b1, DIV, 1'b1, 1'b0, 1000);
    issue(1'b1, MADD, 1'b0, 1'b0, 1000);
    issue(1'b1, MSUBU, 1'b0, 1'b0, 1000);
    issue(1'b1, ADD, 1'b0, 1'b1, 1000);
    issue(1'b0, DIV, 1'b0, 1'b1, 1000);
    // Flush at cnt=10: cycles 0..10 run normally, then flush in the cycle showing cnt=10.
    issue(1'b1, DIV, 1'b0, 1'b1, 11);
    e = '0; e.cnt = 6'd10; e.busy = 1'b1;
    drive(1'b1, 1'b1, DIV, 1'b0, 1'b1, 1'b1, e);
    idle_cycle(1'b1);
    e = '0;
    drive(1'b1, 1'b1, MADD, 1'b0, 1'b1, 1'b1, e);
    idle_cycle(1'b1);
    // Asynchronous reset at cnt=5 with idle inputs, then a fresh DIVU.
    issue(1'b1, DIVU, 1'b0, 1'b0, 6);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    issue(1'b1, DIVU, 1'b0, 1'b1, 1000);
    for (int i = 0; i < 150; i++)
      issue(1'($urandom_range(0, 9) != 0), ops[$urandom_range(0, 7)], 1'($urandom_range(0, 3) == 0), 1'b0, 1000);
    idle_cycle(1'b1);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall and multi-cycle sequencing controller for the five-stage core. It merges stall requests from decode with the busy state of multi-cycle EX operations: DIV/DIVU (iterative) and MADD/MADDU/MSUB/MSUBU (two-phase). It produces the per-stage stall vector and drives the step/phase controls of the shared EX arithmetic datapath. It sits beside the pipeline registers and feeds every stage register's hold input.

## Interface
Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles. Legal range 1..63.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- stallreq_id_i  in  1  load-use hazard request from decode
- ex_valid_i  in  1  EX stage holds a valid instruction
- ex_aluop_i  in  `AluOpBus`  aluop of the EX instruction
- ex_div_zero_i  in  1  EX divisor operand equals zero
- flush_i  in  1  annul all in-flight work
- stall_o  out  6  stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
- div_start_o  out  1  load divider operands (one-cycle pulse)
- div_step_o  out  1  perform one divider iteration
- div_cnt_o  out  6  current iteration index
- div_done_o  out  1  divider result/flags valid this cycle
- div_dz_o  out  1  divide-by-zero result this cycle; qualified by div_done_o
- madd_phase_o  out  1  0 = multiply phase, 1 = accumulate phase
- busy_o  out  1  FSM not in IDLE

## Operation
- Div op means EXE_DIV_OP or EXE_DIVU_OP. Madd op means EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP or EXE_MSUBU_OP.
- FSM states: IDLE, DIV_RUN, DIV_DONE, MADD2.
- IDLE:
  - Valid div op with ex_div_zero_i=1: assert ex stall. Next state DIV_DONE with the dz flag registered.
  - Valid div op with nonzero divisor: assert ex stall and div_start_o. Next state DIV_RUN, cnt ← 0.
  - Valid madd op: assert ex stall, madd_phase_o=0. Next state MADD2.
- DIV_RUN: assert ex stall and div_step_o. Each cycle cnt ← cnt+1. When cnt = DIV_CYCLES-1, go to DIV_DONE and cnt ← 0.
- DIV_DONE: div_done_o=1; div_dz_o = registered dz flag. No ex stall. Next state IDLE.
- MADD2: madd_phase_o=1, no ex stall. Next state IDLE.
- Stall encoding:
  - ex stall → 6'b001111 (mem receives a bubble).
  - id stall only → 6'b000111.
  - Neither → 0.
- Priority: flush_i > ex stall > stallreq_id_i. A simultaneous id request is subsumed by the ex stall.
- flush_i=1 in any state: stall_o=0, div_start_o=0, div_step_o=0. Next state IDLE, cnt ← 0, dz ← 0.
- ex_valid_i and ex_aluop_i are sampled only in IDLE. Changes in other states are ignored, because the EX register is held.
- Aluop values other than div and madd ops leave the FSM in IDLE.

## Timing
- Reset (rst=0, asynchronous): state IDLE, cnt 0, dz 0. Every output is 0 while reset is asserted and in the first cycle after release, provided decode and EX inputs are idle.
- stall_o, div_start_o and madd_phase_o are combinational from state and inputs, so a stall takes effect the same cycle the op is in EX.
- Div with nonzero divisor, accepted at cycle t:
  - t: start pulse.
  - t+1..t+DIV_CYCLES: DIV_RUN, cnt 0..DIV_CYCLES-1.
  - t+DIV_CYCLES+1: DIV_DONE.
  - Result: EX occupancy DIV_CYCLES+2 cycles, ex stall asserted DIV_CYCLES+1 cycles.
- Div by zero: 2 EX cycles (t stall, t+1 done with dz=1). div_step_o is never asserted.
- Madd: 2 EX cycles; stall only in cycle t.
- Back-to-back ops: the next instruction enters EX the cycle after DIV_DONE or MADD2 and is evaluated in IDLE there. There are no dead cycles.
- Reset or flush mid-DIV_RUN aborts with no div_done_o pulse.

## Structure
- Add to the shared defines.v: the state encodings (2 bits), stall vector constants STALL_NONE/STALL_ID/STALL_EX, and the div/madd aluop codes already used by decode and EX.
- Single flat module. The state register, counter and dz flag live in one sequential process. The stall and next-state logic live in one combinational process. No sub-module.

## Test plan
- DIVU, divisor 7, DIV_CYCLES=32 → stall_o=6'b001111 for 33 cycles. div_step_o asserted 32 cycles with div_cnt_o 0..31. div_done_o=1 on cycle 34 with stall_o=0.
- DIV, ex_div_zero_i=1 → one stall cycle. Next cycle div_done_o=1 and div_dz_o=1. div_step_o is never asserted.
- MADD followed immediately by MSUBU → stall pattern 1,0,1,0 on bit3. madd_phase_o=0,1,0,1.
- stallreq_id_i=1 in IDLE with a non-multicycle op → stall_o=6'b000111. Same request during DIV_RUN → stall_o=6'b001111.
- flush_i at DIV_RUN cnt=10 → same cycle stall_o=0. Next cycle busy_o=0 and div_cnt_o=0. No div_done_o pulse.
- rst to 0 at DIV_RUN cnt=5 → all outputs 0 immediately (asynchronous). After release, a new DIVU completes in 34 cycles.
